// File: rtl/snes_pad_responder.sv
`default_nettype none
// ============================================================================
//  Module      : snes_pad_responder
//  Description : Device-side SNES controller emulator. Answers the host's
//                data_latch / data_clock strobes and drives serial_data,
//                one button bit per data_clock rising edge (bit0 first).
//                Host strobes are asynchronous and are synchronized here.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clock        system clock
//    i_reset        asynchronous active-high reset
//    i_data_latch   host latch strobe (async, active high)
//    i_data_clock   host shift clock (async, idles high)
//    i_buttons      parallel button state, active low, bit0 sent first
//    i_turbo_mask   per-button autofire enable (turbo builds only)
//    o_serial_data  serial button bit to host, 0 = pressed
//    o_busy         high while loading or shifting a frame
//    o_bit_count    bits shifted in the current frame, 0..FRAME_BITS
//    o_frame_done   one-cycle pulse when the frame completes
//    o_overrun      one-cycle pulse when latch rises mid-frame
//    o_timeout      one-cycle pulse when the shift timeout expires
//  Optional feature
//    SNES_PAD_TURBO_EN : define to enable turbo (autofire) masking on load.
// ============================================================================
module snes_pad_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int FRAME_BITS     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TURBO_DIV      = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_data_latch,
  input  logic        i_data_clock,
  output logic        o_serial_data,
  input  logic [15:0] i_buttons,
  input  logic [15:0] i_turbo_mask,
  output logic        o_busy,
  output logic [4:0]  o_bit_count,
  output logic        o_frame_done,
  output logic        o_overrun,
  output logic        o_timeout
);

  localparam int              c_TMR_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0]      c_FRAME_BITS = 5'(FRAME_BITS);
  localparam logic [c_TMR_W-1:0] c_TMO     = c_TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronizers and edge detection
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_latch_sync;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic                   r_latch_q;
  logic                   r_clk_q;
  logic                   w_latch_s;
  logic                   w_clk_s;
  logic                   w_latch_rise;
  logic                   w_latch_fall;
  logic                   w_clk_rise;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_latch_sync <= '0;
      r_clk_sync   <= '1;   // data_clock idles high
      r_latch_q    <= 1'b0;
      r_clk_q      <= 1'b1;
    end else begin
      r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], i_data_latch};
      r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], i_data_clock};
      r_latch_q    <= w_latch_s;
      r_clk_q      <= w_clk_s;
    end
  end

  assign w_latch_s    = r_latch_sync[SYNC_STAGES-1];
  assign w_clk_s      = r_clk_sync[SYNC_STAGES-1];
  assign w_latch_rise = w_latch_s & ~r_latch_q;
  assign w_latch_fall = ~w_latch_s & r_latch_q;
  assign w_clk_rise   = w_clk_s & ~r_clk_q;

  // --------------------------------------------------------------------------
  // Value loaded into the shift register while in LOAD
  // --------------------------------------------------------------------------
  logic [15:0] w_load_val;

`ifdef SNES_PAD_TURBO_EN
  localparam int                  c_TDIV_W    = $clog2(TURBO_DIV + 1);
  localparam logic [c_TDIV_W-1:0] c_TDIV_LAST = c_TDIV_W'(TURBO_DIV - 1);

  logic [c_TDIV_W-1:0] r_frame_cnt;
  logic                r_phase;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_frame_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_latch_fall) begin
      if (r_frame_cnt == c_TDIV_LAST) begin
        r_frame_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + c_TDIV_W'(1);
      end
    end
  end

  // A pressed (0) turbo button is forced to released (1) during phase 1.
  assign w_load_val = i_buttons | (i_turbo_mask & {16{r_phase}});
`else
  logic w_unused_turbo;
  assign w_unused_turbo = ^i_turbo_mask;
  assign w_load_val     = i_buttons;
`endif

  // --------------------------------------------------------------------------
  // Frame state machine
  // --------------------------------------------------------------------------
  state_t               r_state;
  state_t               w_state_n;
  logic [15:0]          r_shreg;
  logic [15:0]          w_shreg_n;
  logic [4:0]           r_cnt;
  logic [4:0]           w_cnt_n;
  logic [4:0]           w_cnt_inc;
  logic [c_TMR_W-1:0]   r_tmr;
  logic [c_TMR_W-1:0]   w_tmr_n;
  logic [c_TMR_W-1:0]   w_tmr_inc;
  logic                 r_sdata;
  logic                 w_sdata_n;
  logic                 r_frame_done;
  logic                 w_frame_done_n;
  logic                 r_overrun;
  logic                 w_overrun_n;
  logic                 r_timeout;
  logic                 w_timeout_n;

  assign w_cnt_inc = r_cnt + 5'd1;
  assign w_tmr_inc = r_tmr + c_TMR_W'(1);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_shreg      <= 16'hFFFF;
      r_cnt        <= 5'd0;
      r_tmr        <= '0;
      r_sdata      <= 1'b1;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_shreg      <= w_shreg_n;
      r_cnt        <= w_cnt_n;
      r_tmr        <= w_tmr_n;
      r_sdata      <= w_sdata_n;
      r_frame_done <= w_frame_done_n;
      r_overrun    <= w_overrun_n;
      r_timeout    <= w_timeout_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_shreg_n      = r_shreg;
    w_cnt_n        = r_cnt;
    w_tmr_n        = r_tmr;
    w_frame_done_n = 1'b0;
    w_overrun_n    = 1'b0;
    w_timeout_n    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_latch_rise) begin
          w_state_n = S_LOAD;
          w_cnt_n   = 5'd0;
        end
      end

      // Buttons are tracked every cycle, including the latch-fall cycle, so
      // the frame carries the state seen at the moment of the fall. Any
      // clock edge coinciding with the fall is deliberately dropped.
      S_LOAD: begin
        w_shreg_n = w_load_val;
        w_cnt_n   = 5'd0;
        w_tmr_n   = '0;
        if (w_latch_fall) begin
          w_state_n = S_SHIFT;
        end
      end

      // Latch has priority over a simultaneous clock edge.
      S_SHIFT: begin
        if (w_latch_rise) begin
          w_overrun_n = 1'b1;
          w_state_n   = S_LOAD;
          w_cnt_n     = 5'd0;
        end else if (w_clk_rise) begin
          w_shreg_n = {1'b0, r_shreg[15:1]};
          w_cnt_n   = w_cnt_inc;
          w_tmr_n   = '0;
          if (w_cnt_inc == c_FRAME_BITS) begin
            w_frame_done_n = 1'b1;
            w_state_n      = S_DONE;
          end
        end else begin
          w_tmr_n = w_tmr_inc;
          if (w_tmr_inc == c_TMO) begin
            w_timeout_n = 1'b1;
            w_state_n   = S_IDLE;
            w_shreg_n   = 16'hFFFF;
            w_cnt_n     = 5'd0;
            w_tmr_n     = '0;
          end
        end
      end

      // bit_count holds at FRAME_BITS; extra clocks are ignored.
      S_DONE: begin
        if (w_latch_rise) begin
          w_state_n = S_LOAD;
          w_cnt_n   = 5'd0;
        end
      end

      default: begin
        w_state_n = S_IDLE;
        w_shreg_n = 16'hFFFF;
        w_cnt_n   = 5'd0;
        w_tmr_n   = '0;
      end
    endcase

    // Fill bits after the frame read as pressed, like a genuine pad.
    w_sdata_n = (w_state_n == S_DONE) ? 1'b0 : w_shreg_n[0];
  end

  assign o_serial_data = r_sdata;
  assign o_busy        = (r_state == S_LOAD) || (r_state == S_SHIFT);
  assign o_bit_count   = r_cnt;
  assign o_frame_done  = r_frame_done;
  assign o_overrun     = r_overrun;
  assign o_timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_snes_pad_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snes_pad_responder
//  Description : Directed self-checking bench for snes_pad_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snes_pad_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        latch = 1'b0;
  logic        dclk = 1'b1;
  logic [15:0] buttons = 16'hFFFF;
  logic [15:0] tmask = 16'h0000;
  logic        sdata;
  logic        busy;
  logic [4:0]  bcnt;
  logic        fdone;
  logic        ovr;
  logic        tmo;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  int ov_cnt   = 0;
  int to_cnt   = 0;

  snes_pad_responder #(
    .SYNC_STAGES   (2),
    .FRAME_BITS    (16),
    .TIMEOUT_CYCLES(4096),
    .TURBO_DIV     (1)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_data_latch (latch),
    .i_data_clock (dclk),
    .o_serial_data(sdata),
    .i_buttons    (buttons),
    .i_turbo_mask (tmask),
    .o_busy       (busy),
    .o_bit_count  (bcnt),
    .o_frame_done (fdone),
    .o_overrun    (ovr),
    .o_timeout    (tmo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fdone) fd_cnt++;
    if (ovr)   ov_cnt++;
    if (tmo)   to_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; latch = 1'b0; dclk = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
  endtask

  task automatic latch_pulse();
    latch = 1'b1;
    wait_cyc(6);
    latch = 1'b0;
    wait_cyc(6);
  endtask

  task automatic clk_pulse();
    dclk = 1'b0;
    wait_cyc(4);
    dclk = 1'b1;
    wait_cyc(4);
  endtask

  task automatic test_reset();
    do_reset();
    if (sdata !== 1'b1)  begin $display("FAIL reset_sdata: got %b want 1", sdata); n_fail++; end n_checks++;
    if (busy !== 1'b0)   begin $display("FAIL reset_busy: got %b want 0", busy); n_fail++; end n_checks++;
    if (bcnt !== 5'd0)   begin $display("FAIL reset_bcnt: got %0d want 0", bcnt); n_fail++; end n_checks++;
    wait_cyc(50);
    if (sdata !== 1'b1 || busy !== 1'b0 || bcnt !== 5'd0)
      begin $display("FAIL idle_hold: sdata=%b busy=%b bcnt=%0d want 1 0 0", sdata, busy, bcnt); n_fail++; end n_checks++;
    if (fd_cnt + ov_cnt + to_cnt !== 0)
      begin $display("FAIL idle_pulses: got %0d want 0", fd_cnt + ov_cnt + to_cnt); n_fail++; end n_checks++;
  endtask

  task automatic test_frame();
    logic [15:0] b;
    int fd0;
    do_reset();
    b = 16'hFFFE;
    buttons = b;
    fd0 = fd_cnt;
    latch = 1'b1;
    wait_cyc(6);
    if (busy !== 1'b1) begin $display("FAIL load_busy: got %b want 1", busy); n_fail++; end n_checks++;
    latch = 1'b0;
    wait_cyc(6);
    for (int i = 0; i < 16; i++) begin
      if (sdata !== b[i]) begin $display("FAIL frame_bit%0d: got %b want %b", i, sdata, b[i]); n_fail++; end n_checks++;
      if (bcnt !== 5'(i)) begin $display("FAIL frame_cnt%0d: got %0d want %0d", i, bcnt, i); n_fail++; end n_checks++;
      clk_pulse();
    end
    if (sdata !== 1'b0)     begin $display("FAIL done_fill: got %b want 0", sdata); n_fail++; end n_checks++;
    if (bcnt !== 5'd16)     begin $display("FAIL done_cnt: got %0d want 16", bcnt); n_fail++; end n_checks++;
    if (busy !== 1'b0)      begin $display("FAIL done_busy: got %b want 0", busy); n_fail++; end n_checks++;
    if (fd_cnt - fd0 !== 1) begin $display("FAIL frame_done_pulses: got %0d want 1", fd_cnt - fd0); n_fail++; end n_checks++;
    clk_pulse();
    clk_pulse();
    if (bcnt !== 5'd16 || sdata !== 1'b0)
      begin $display("FAIL done_saturate: bcnt=%0d sdata=%b want 16 0", bcnt, sdata); n_fail++; end n_checks++;
    if (fd_cnt - fd0 !== 1) begin $display("FAIL done_extra_pulse: got %0d want 1", fd_cnt - fd0); n_fail++; end n_checks++;
    // Re-latch from DONE loads a fresh frame
    buttons = 16'h0001;
    latch_pulse();
    if (sdata !== 1'b1 || bcnt !== 5'd0 || busy !== 1'b1)
      begin $display("FAIL relatch_done: sdata=%b bcnt=%0d busy=%b want 1 0 1", sdata, bcnt, busy); n_fail++; end n_checks++;
  endtask

  task automatic test_overrun();
    int ov0;
    do_reset();
    ov0 = ov_cnt;
    buttons = 16'h5A5A;
    latch_pulse();
    repeat (8) clk_pulse();
    if (bcnt !== 5'd8)  begin $display("FAIL ovr_pre_cnt: got %0d want 8", bcnt); n_fail++; end n_checks++;
    if (sdata !== 1'b0) begin $display("FAIL ovr_pre_bit8: got %b want 0", sdata); n_fail++; end n_checks++;
    buttons = 16'h3C3D;
    latch = 1'b1;
    wait_cyc(6);
    if (ov_cnt - ov0 !== 1) begin $display("FAIL overrun_pulse: got %0d want 1", ov_cnt - ov0); n_fail++; end n_checks++;
    if (bcnt !== 5'd0)      begin $display("FAIL overrun_cnt: got %0d want 0", bcnt); n_fail++; end n_checks++;
    latch = 1'b0;
    wait_cyc(6);
    if (sdata !== 1'b1) begin $display("FAIL overrun_bit0: got %b want 1", sdata); n_fail++; end n_checks++;
    // Button changes mid-frame must not leak into the frame in flight
    buttons = 16'h0000;
    clk_pulse();
    clk_pulse();
    if (sdata !== 1'b1 || bcnt !== 5'd2)
      begin $display("FAIL shift_isolation: sdata=%b bcnt=%0d want 1 2", sdata, bcnt); n_fail++; end n_checks++;
  endtask

  task automatic test_timeout();
    int k;
    int to0;
    bit seen;
    do_reset();
    to0 = to_cnt;
    buttons = 16'h0000;
    latch_pulse();
    clk_pulse();
    clk_pulse();
    dclk = 1'b0;
    wait_cyc(4);
    dclk = 1'b1;
    k = 0;
    while (bcnt !== 5'd3 && k < 20) begin @(negedge clk); k++; end
    if (bcnt !== 5'd3) begin $display("FAIL tmo_third_shift: got %0d want 3", bcnt); n_fail++; end n_checks++;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 5000) begin
      @(negedge clk);
      k++;
      if (tmo === 1'b1) seen = 1'b1;
    end
    if (k !== 4096) begin $display("FAIL tmo_latency: got %0d cycles want 4096", k); n_fail++; end n_checks++;
    wait_cyc(3);
    if (busy !== 1'b0)        begin $display("FAIL tmo_busy: got %b want 0", busy); n_fail++; end n_checks++;
    if (sdata !== 1'b1)       begin $display("FAIL tmo_sdata: got %b want 1", sdata); n_fail++; end n_checks++;
    if (to_cnt - to0 !== 1)   begin $display("FAIL tmo_pulses: got %0d want 1", to_cnt - to0); n_fail++; end n_checks++;
  endtask

  task automatic test_simultaneous();
    int ov0;
    do_reset();
    buttons = 16'hAAA9;
    latch_pulse();
    clk_pulse();
    clk_pulse();
    ov0 = ov_cnt;
    dclk = 1'b0;
    wait_cyc(4);
    latch = 1'b1;
    dclk  = 1'b1;
    wait_cyc(6);
    if (bcnt !== 5'd0)      begin $display("FAIL sim_rise_cnt: got %0d want 0", bcnt); n_fail++; end n_checks++;
    if (ov_cnt - ov0 !== 1) begin $display("FAIL sim_rise_overrun: got %0d want 1", ov_cnt - ov0); n_fail++; end n_checks++;
    dclk = 1'b0;
    wait_cyc(4);
    latch = 1'b0;
    dclk  = 1'b1;
    wait_cyc(6);
    if (bcnt !== 5'd0)  begin $display("FAIL sim_fall_cnt: got %0d want 0", bcnt); n_fail++; end n_checks++;
    if (sdata !== 1'b1) begin $display("FAIL sim_fall_bit0: got %b want 1", sdata); n_fail++; end n_checks++;
    clk_pulse();
    if (sdata !== 1'b0 || bcnt !== 5'd1)
      begin $display("FAIL sim_next_shift: sdata=%b bcnt=%0d want 0 1", sdata, bcnt); n_fail++; end n_checks++;
  endtask

  task automatic test_async_reset();
    int p0;
    do_reset();
    buttons = 16'h0000;
    latch_pulse();
    repeat (3) clk_pulse();
    p0 = fd_cnt + ov_cnt + to_cnt;
    #2 rst = 1'b1;
    #1;
    if (sdata !== 1'b1 || busy !== 1'b0 || bcnt !== 5'd0)
      begin $display("FAIL async_reset: sdata=%b busy=%b bcnt=%0d want 1 0 0", sdata, busy, bcnt); n_fail++; end n_checks++;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(3);
    if (fd_cnt + ov_cnt + to_cnt - p0 !== 0)
      begin $display("FAIL async_reset_pulses: got %0d want 0", fd_cnt + ov_cnt + to_cnt - p0); n_fail++; end n_checks++;
  endtask

  task automatic test_turbo();
    logic [3:0] exp;
`ifdef SNES_PAD_TURBO_EN
    exp = 4'b1010;
`else
    exp = 4'b0000;
`endif
    do_reset();
    buttons = 16'hFFFE;
    tmask   = 16'h0001;
    for (int f = 0; f < 4; f++) begin
      latch_pulse();
      if (sdata !== exp[f]) begin $display("FAIL turbo_frame%0d: got %b want %b", f, sdata, exp[f]); n_fail++; end n_checks++;
    end
    tmask = 16'h0000;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_overrun();
    test_timeout();
    test_simultaneous();
    test_async_reset();
    test_turbo();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snes_pad_responder.md
Name: snes_pad_responder

Overview:
- Device-side end of the SNES controller serial protocol: it answers the data_latch/data_clock strobes from a host and drives serial_data.
- Used as an on-board pad emulator, so a host-side controller interface can be run and verified without physical hardware.
- Button state is supplied in parallel; it is captured on latch and shifted out one bit per data_clock pulse.
- All host strobes are asynchronous to clock and are synchronized inside the block.

Parameters:
SYNC_STAGES, 2, synchronizer flops on data_latch and data_clock (minimum 2)
FRAME_BITS, 16, bits per frame before fill data is driven
TIMEOUT_CYCLES, 4096, clock cycles without a data_clock rising edge in SHIFT before the frame is abandoned
TURBO_DIV, 4, frames per turbo half-period (used only with the optional feature)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
data_latch  in  1  host latch strobe, asynchronous, active high
data_clock  in  1  host shift clock, asynchronous, idles high
serial_data  out  1  serial button bit to host; 0 = pressed
buttons  in  16  parallel button state, active low; bit0 is sent first (B)
turbo_mask  in  16  per-button autofire enable (used only with the optional feature)
busy  out  1  high in LOAD or SHIFT
bit_count  out  5  bits shifted in the current frame, 0..FRAME_BITS
frame_done  out  1  one-cycle pulse when FRAME_BITS shifts complete
overrun  out  1  one-cycle pulse when latch rises mid-frame
timeout  out  1  one-cycle pulse when the SHIFT timeout expires

Behaviour:
- Reset values (async): state=IDLE, shift register=16'hFFFF, serial_data=1, bit_count=0, busy=0, frame_done=0, overrun=0, timeout=0. Synchronizer flops reset to latch=0, clk=1.
- Edge detect runs on the synchronized signals. An event registers SYNC_STAGES+1 clock cycles after the pin edge.
- serial_data is registered and always equals shreg[0], except in DONE, where it is 0.
- States:
  - IDLE: on latch rise → LOAD.
  - LOAD: shreg <= buttons every cycle; bit_count=0. data_clock edges are ignored. On latch fall → SHIFT, so serial_data presents bit0.
  - SHIFT: on each data_clock rising edge: shreg <= {1'b0, shreg[15:1]}, bit_count++, timeout counter cleared. When bit_count reaches FRAME_BITS: frame_done pulses and state → DONE.
  - DONE: serial_data=0 (fill, which the host reads as pressed, matching genuine pads). Further clocks are ignored and bit_count saturates at FRAME_BITS. On latch rise → LOAD.
- Timeout: in SHIFT, a counter increments each cycle. At TIMEOUT_CYCLES it pulses timeout and goes to IDLE with shreg=16'hFFFF.
- Latch rise while in SHIFT → overrun pulse, then LOAD (frame aborted).
- Latch rise and clock rise detected in the same cycle: latch wins and the clock edge is dropped.
- A clock rise already pending when latch falls is not applied; only edges detected after entry to SHIFT shift.
- buttons is sampled only in LOAD. Changes during SHIFT do not affect the frame in flight.
- Reset asserted mid-frame: immediate return to reset values, with no pulses emitted.

Optional Feature:
- Macro: SNES_PAD_TURBO_EN.
- Defined:
  - A frame counter increments on every latch fall.
  - A turbo phase bit toggles every TURBO_DIV frames.
  - On LOAD, for each bit with turbo_mask=1 and buttons=0, the loaded bit is 1 when phase=1, so the button reads released on alternating phases.
  - Phase and counter reset to 0.
- Undefined: turbo_mask is ignored and no counter logic is generated.

Test Plan:
- Reset, no strobes → serial_data=1, busy=0, bit_count=0 indefinitely.
- buttons=16'hFFFE, latch pulse, then 16 clock pulses → serial_data sequence 0,1,1,…,1; frame_done pulses once after the 16th clock; bit_count=16; then serial_data=0.
- buttons=16'h5A5A, latch, 8 clocks, latch again → overrun pulse; the new frame restarts from bit0 of the newly loaded buttons.
- Latch, 3 clocks, then silence for TIMEOUT_CYCLES → timeout pulse at cycle TIMEOUT_CYCLES; state IDLE; serial_data=1.
- Latch and data_clock rising on the same cycle → no shift; bit_count=0; serial_data=buttons[0] after latch falls.
- With SNES_PAD_TURBO_EN, TURBO_DIV=1, turbo_mask=16'h0001, buttons=16'hFFFE → first bit alternates 0,1,0,1 on successive frames. Without the macro, the first bit is 0 on every frame.
